// File: rtl/hsv_pkg.sv
// Shared widths, FSM state type, overlay colours and helpers for the HSV matcher.
package hsv_pkg;
  localparam int H_W     = 14;
  localparam int COORD_W = 13;
  localparam int CNT_W   = 20;

  localparam logic [COORD_W-1:0] COORD_MAX = 13'd8191;
  localparam logic [CNT_W-1:0]   CNT_MAX   = 20'hFFFFF;

  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

  localparam logic [23:0] OVL_MATCH_RGB = 24'h00FF00;
  localparam logic [23:0] OVL_EDGE_RGB  = 24'hFF0000;

  function automatic logic [H_W:0] abs_s(input logic signed [H_W:0] x);
    logic [H_W:0] r;
    r = x[H_W] ? -x : x;
    return r;
  endfunction
endpackage

// File: rtl/hsv_convert.sv
// RGB -> unnormalised (H, diff, max); 2-cycle latency, one pixel per cycle, no backpressure.
module hsv_convert
  import hsv_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            r,
  input  logic [7:0]            g,
  input  logic [7:0]            b,
  output logic signed [H_W-1:0] h,
  output logic [7:0]            diff,
  output logic [7:0]            vmax
);
  logic [7:0]     mx, mn, r1, g1, b1, max1, min1, d1;
  logic [H_W-1:0] rz, gz, bz, dz, h_d;

  always_comb begin
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r1   <= '0;
      g1   <= '0;
      b1   <= '0;
      max1 <= '0;
      min1 <= '0;
    end else begin
      r1   <= r;
      g1   <= g;
      b1   <= b;
      max1 <= mx;
      min1 <= mn;
    end
  end

  // Equality checks in R, G, B order give the tie-break for free.
  always_comb begin
    d1 = max1 - min1;
    rz = {{(H_W-8){1'b0}}, r1};
    gz = {{(H_W-8){1'b0}}, g1};
    bz = {{(H_W-8){1'b0}}, b1};
    dz = {{(H_W-8){1'b0}}, d1};
    if (max1 == r1)      h_d = gz - bz;
    else if (max1 == g1) h_d = (bz - rz) + (dz << 1);
    else                 h_d = (rz - gz) + (dz << 2);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h    <= '0;
      diff <= '0;
      vmax <= '0;
    end else begin
      h    <= h_d;
      diff <= d1;
      vmax <= max1;
    end
  end
endmodule

// File: rtl/hsv_match_tracker.sv
// Colour matcher + per-frame bbox; 3-cycle pixel latency, box_valid 4 cycles after frame_end, no backpressure.
// Optional output overlay of matches and the previous box: define HSV_MATCH_OVERLAY_EN.
module hsv_match_tracker
  import hsv_pkg::*;
#(
  parameter logic [H_W-1:0]   H_TOL     = 14'd8,
  parameter logic [7:0]       S_TOL     = 8'd16,
  parameter logic [7:0]       V_TOL     = 8'd32,
  parameter logic [CNT_W-1:0] MIN_COUNT = 20'd16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pix_valid,
  input  logic [7:0]            raw_R,
  input  logic [7:0]            raw_G,
  input  logic [7:0]            raw_B,
  input  logic [COORD_W-1:0]    row,
  input  logic [COORD_W-1:0]    col,
  input  logic                  frame_end,
  input  logic                  ref_valid,
  input  logic signed [H_W-1:0] ref_H,
  input  logic [7:0]            ref_S,
  input  logic [7:0]            ref_V,
  output logic                  match,
  output logic                  match_valid,
  output logic [7:0]            out_R,
  output logic [7:0]            out_G,
  output logic [7:0]            out_B,
  output logic                  box_valid,
  output logic                  box_found,
  output logic [CNT_W-1:0]      box_count,
  output logic [COORD_W-1:0]    box_rmin,
  output logic [COORD_W-1:0]    box_rmax,
  output logic [COORD_W-1:0]    box_cmin,
  output logic [COORD_W-1:0]    box_cmax
);
  state_t                state_q, state_d;
  logic                  latch_ref, report_go;
  logic signed [H_W-1:0] ref_h_q;
  logic [7:0]            ref_s_q, ref_v_q;

  logic                  v1, v2, fe1, fe2, fe3;
  logic [7:0]            r1, g1, b1, r2, g2, b2;
  logic [COORD_W-1:0]    row1, row2, row3, col1, col2, col3;
  logic signed [H_W-1:0] h2;
  logic [7:0]            diff2, max2;

  logic signed [H_W:0]   dh, ds, dv;
  logic                  hit, match_en, match_d;
  logic [23:0]           pix_d;

  logic [CNT_W-1:0]      cnt_q, b_cnt, cnt_n;
  logic [COORD_W-1:0]    rmin_q, rmax_q, cmin_q, cmax_q;
  logic [COORD_W-1:0]    b_rmin, b_rmax, b_cmin, b_cmax;
  logic [COORD_W-1:0]    rmin_n, rmax_n, cmin_n, cmax_n;
  logic                  clr, acc_en;

  hsv_convert u_convert (
    .clk     (clk),
    .reset_n (reset_n),
    .r       (raw_R),
    .g       (raw_G),
    .b       (raw_B),
    .h       (h2),
    .diff    (diff2),
    .vmax    (max2)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1 <= 1'b0;  v2 <= 1'b0;  fe1 <= 1'b0;  fe2 <= 1'b0;
      r1 <= '0;  g1 <= '0;  b1 <= '0;  r2 <= '0;  g2 <= '0;  b2 <= '0;
      row1 <= '0;  row2 <= '0;  col1 <= '0;  col2 <= '0;
    end else begin
      v1 <= pix_valid;  v2 <= v1;
      fe1 <= frame_end; fe2 <= fe1;
      r1 <= raw_R;  g1 <= raw_G;  b1 <= raw_B;
      r2 <= r1;     g2 <= g1;     b2 <= b1;
      row1 <= row;  row2 <= row1;
      col1 <= col;  col2 <= col1;
    end
  end

  // A pixel compared while REPORT is active belongs to the next frame, so it
  // only counts if the FSM is heading back to TRACK.
  always_comb begin
    dh = {h2[H_W-1], h2} - {ref_h_q[H_W-1], ref_h_q};
    ds = {7'd0, diff2} - {7'd0, ref_s_q};
    dv = {7'd0, max2} - {7'd0, ref_v_q};
    hit = (abs_s(dh) <= {1'b0, H_TOL}) &&
          (abs_s(ds) <= {7'd0, S_TOL}) &&
          (abs_s(dv) <= {7'd0, V_TOL});
    match_en = (state_q == TRACK) || ((state_q == REPORT) && ref_valid);
    match_d  = v2 && match_en && hit;
  end

`ifdef HSV_MATCH_OVERLAY_EN
  logic in_box, on_edge;
  always_comb begin
    in_box  = (box_count != '0) &&
              (row2 >= box_rmin) && (row2 <= box_rmax) &&
              (col2 >= box_cmin) && (col2 <= box_cmax);
    on_edge = in_box && ((row2 == box_rmin) || (row2 == box_rmax) ||
                         (col2 == box_cmin) || (col2 == box_cmax));
    pix_d = {r2, g2, b2};
    if (on_edge)      pix_d = OVL_EDGE_RGB;
    else if (match_d) pix_d = OVL_MATCH_RGB;
  end
`else
  assign pix_d = {r2, g2, b2};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      match       <= 1'b0;
      match_valid <= 1'b0;
      {out_R, out_G, out_B} <= '0;
      fe3  <= 1'b0;
      row3 <= '0;
      col3 <= '0;
    end else begin
      match       <= match_d;
      match_valid <= v2;
      {out_R, out_G, out_B} <= pix_d;
      fe3  <= fe2;
      row3 <= row2;
      col3 <= col2;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_ref = 1'b0;
    case (state_q)
      IDLE: begin
        if (ref_valid) begin
          state_d   = TRACK;
          latch_ref = 1'b1;
        end
      end
      TRACK:   if (fe3) state_d = REPORT;
      REPORT:  state_d = ref_valid ? TRACK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next accumulator values; REPORT restarts from the empty-frame values.
  always_comb begin
    clr       = (state_q == REPORT);
    report_go = (state_q == TRACK) && fe3;
    acc_en    = match && ((state_q == TRACK) || (clr && ref_valid));
    b_cnt  = clr ? '0        : cnt_q;
    b_rmin = clr ? COORD_MAX : rmin_q;
    b_rmax = clr ? '0        : rmax_q;
    b_cmin = clr ? COORD_MAX : cmin_q;
    b_cmax = clr ? '0        : cmax_q;
    cnt_n  = b_cnt;
    rmin_n = b_rmin;
    rmax_n = b_rmax;
    cmin_n = b_cmin;
    cmax_n = b_cmax;
    if (acc_en) begin
      if (b_cnt != CNT_MAX) cnt_n = b_cnt + 1'b1;
      if (row3 < b_rmin)    rmin_n = row3;
      if (row3 > b_rmax)    rmax_n = row3;
      if (col3 < b_cmin)    cmin_n = col3;
      if (col3 > b_cmax)    cmax_n = col3;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ref_h_q   <= '0;
      ref_s_q   <= '0;
      ref_v_q   <= '0;
      cnt_q     <= '0;
      rmin_q    <= COORD_MAX;
      rmax_q    <= '0;
      cmin_q    <= COORD_MAX;
      cmax_q    <= '0;
      box_valid <= 1'b0;
      box_found <= 1'b0;
      box_count <= '0;
      box_rmin  <= '0;
      box_rmax  <= '0;
      box_cmin  <= '0;
      box_cmax  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ref) begin
        ref_h_q <= ref_H;
        ref_s_q <= ref_S;
        ref_v_q <= ref_V;
      end
      cnt_q  <= cnt_n;
      rmin_q <= rmin_n;
      rmax_q <= rmax_n;
      cmin_q <= cmin_n;
      cmax_q <= cmax_n;
      box_valid <= report_go;
      if (report_go) begin
        box_count <= cnt_n;
        box_found <= (cnt_n != '0) && (cnt_n >= MIN_COUNT);
        if (cnt_n == '0) begin
          box_rmin <= '0;
          box_rmax <= '0;
          box_cmin <= '0;
          box_cmax <= '0;
        end else begin
          box_rmin <= rmin_n;
          box_rmax <= rmax_n;
          box_cmin <= cmin_n;
          box_cmax <= cmax_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_hsv_match_tracker.sv
// Bench for hsv_match_tracker: table-driven pixel vectors plus frame-level sequences, scoreboard-checked.
module tb_hsv_match_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n, pix_valid, frame_end, ref_valid;
  logic [7:0]         raw_R, raw_G, raw_B, ref_S, ref_V;
  logic [12:0]        row, col;
  logic signed [13:0] ref_H;
  logic               match, match_valid, box_valid, box_found;
  logic [7:0]         out_R, out_G, out_B;
  logic [19:0]        box_count;
  logic [12:0]        box_rmin, box_rmax, box_cmin, box_cmax;

  hsv_match_tracker dut (
    .clk(clk), .reset_n(reset_n), .pix_valid(pix_valid),
    .raw_R(raw_R), .raw_G(raw_G), .raw_B(raw_B),
    .row(row), .col(col), .frame_end(frame_end),
    .ref_valid(ref_valid), .ref_H(ref_H), .ref_S(ref_S), .ref_V(ref_V),
    .match(match), .match_valid(match_valid),
    .out_R(out_R), .out_G(out_G), .out_B(out_B),
    .box_valid(box_valid), .box_found(box_found), .box_count(box_count),
    .box_rmin(box_rmin), .box_rmax(box_rmax), .box_cmin(box_cmin), .box_cmax(box_cmax)
  );

  typedef struct { logic m; logic [7:0] r, g, b; int cyc; } pix_exp_t;
  typedef struct { logic found; logic [19:0] cnt; logic [12:0] rmin, rmax, cmin, cmax; int cyc; } box_exp_t;
  typedef struct { logic [7:0] r, g, b; logic hit; } vec_t;

  pix_exp_t sb[$];
  box_exp_t bsb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic trk = 1'b0;
  int   mcnt;
  logic [12:0] mrmin, mrmax, mcmin, mcmax;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mcnt = 0;
    mrmin = 13'd8191; mrmax = 13'd0;
    mcmin = 13'd8191; mcmax = 13'd0;
  endtask

  task automatic model_add(input logic [12:0] rw, input logic [12:0] cl);
    if (mcnt < 20'hFFFFF) mcnt++;
    if (rw < mrmin) mrmin = rw;
    if (rw > mrmax) mrmax = rw;
    if (cl < mcmin) mcmin = cl;
    if (cl > mcmax) mcmax = cl;
  endtask

  // Frame end presented this cycle: report expected 4 cycles later.
  task automatic push_box();
    box_exp_t e;
    if (trk) begin
      e.found = (mcnt >= 16);
      e.cnt   = 20'(mcnt);
      e.rmin  = (mcnt == 0) ? 13'd0 : mrmin;
      e.rmax  = (mcnt == 0) ? 13'd0 : mrmax;
      e.cmin  = (mcnt == 0) ? 13'd0 : mcmin;
      e.cmax  = (mcnt == 0) ? 13'd0 : mcmax;
      e.cyc   = cyc + 4;
      bsb.push_back(e);
    end
    model_reset();
  endtask

  task automatic step();
    pix_exp_t e;
    box_exp_t b;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (match_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL pix_unexpected: actual match_valid=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("pix_out", {match, out_R, out_G, out_B}, {e.m, e.r, e.g, e.b});
        chk("pix_latency", cyc, e.cyc);
      end
    end
    if (box_valid) begin
      if (bsb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL box_unexpected: actual box_valid=1 required=0 (cycle %0d)", cyc);
      end else begin
        b = bsb.pop_front();
        chk("box_report", {box_found, box_count, box_rmin, box_rmax, box_cmin, box_cmax},
            {b.found, b.cnt, b.rmin, b.rmax, b.cmin, b.cmax});
        chk("box_latency", cyc, b.cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                           input logic [12:0] rw, input logic [12:0] cl,
                           input logic hit, input logic fe);
    pix_exp_t e;
    pix_valid = 1'b1;
    raw_R = r; raw_G = g; raw_B = b;
    row = rw; col = cl;
    frame_end = fe;
    e.m = trk && hit;
    e.r = r; e.g = g; e.b = b;
    e.cyc = cyc + 3;
    sb.push_back(e);
    if (e.m) model_add(rw, cl);
    if (fe) push_box();
    step();
    pix_valid = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic send_fe();
    frame_end = 1'b1;
    push_box();
    step();
    frame_end = 1'b0;
  endtask

  initial begin
    vec_t vecs[13];
    reset_n = 1'b0; pix_valid = 1'b0; frame_end = 1'b0; ref_valid = 1'b0;
    raw_R = '0; raw_G = '0; raw_B = '0; row = '0; col = '0;
    ref_H = 14'sd50; ref_S = 8'd150; ref_V = 8'd200;

    // Reference H=50, diff=150, max=200; tolerances 8/16/32.
    vecs[0]  = '{8'd200, 8'd100, 8'd50,  1'b1};  // exact
    vecs[1]  = '{8'd50,  8'd200, 8'd100, 1'b0};  // H=350
    vecs[2]  = '{8'd200, 8'd108, 8'd50,  1'b1};  // H=58
    vecs[3]  = '{8'd200, 8'd109, 8'd50,  1'b0};  // H=59
    vecs[4]  = '{8'd200, 8'd116, 8'd66,  1'b1};  // diff=134
    vecs[5]  = '{8'd200, 8'd117, 8'd67,  1'b0};  // diff=133
    vecs[6]  = '{8'd232, 8'd132, 8'd82,  1'b1};  // max=232
    vecs[7]  = '{8'd233, 8'd133, 8'd83,  1'b0};  // max=233
    vecs[8]  = '{8'd168, 8'd68,  8'd18,  1'b1};  // max=168
    vecs[9]  = '{8'd167, 8'd67,  8'd17,  1'b0};  // max=167
    vecs[10] = '{8'd200, 8'd50,  8'd100, 1'b0};  // H=-50
    vecs[11] = '{8'd200, 8'd92,  8'd50,  1'b1};  // H=42
    vecs[12] = '{8'd100, 8'd50,  8'd200, 1'b0};  // B max, H=650

    model_reset();
    idle(3);
    chk("rst_flags", {match, match_valid, box_valid, box_found}, 4'b0000);
    chk("rst_count", box_count, 20'd0);
    chk("rst_coords", {box_rmin, box_rmax, box_cmin, box_cmax}, 52'd0);
    chk("rst_pixel", {out_R, out_G, out_B}, 24'd0);
    reset_n = 1'b1;
    idle(2);

    // No calibration: no match, no report.
    trk = 1'b0;
    for (int i = 0; i < 4; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'd5, 13'(i), 1'b1, 1'b0);
    send_fe();
    idle(6);

    ref_valid = 1'b1;
    idle(2);
    trk = 1'b1;
    for (int i = 0; i < 13; i++)
      drive_pix(vecs[i].r, vecs[i].g, vecs[i].b, 13'(i), 13'(100 + i), vecs[i].hit, 1'b0);
    send_fe();
    idle(6);

    for (int r = 10; r <= 14; r++)
      for (int c = 30; c <= 33; c++)
        drive_pix(8'd200, 8'd100, 8'd50, 13'(r), 13'(c), 1'b1, 1'b0);
    send_fe();
    idle(6);

    send_fe();
    idle(6);

    // Last pixel coincident with frame_end; stream continues straight into the next frame.
    for (int i = 0; i < 3; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'(40 + i), 13'd50, 1'b1, 1'b0);
    drive_pix(8'd200, 8'd100, 8'd50, 13'd43, 13'd51, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'(60 + i), 13'd70, 1'b1, 1'b0);
    send_fe();
    idle(6);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 10; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'd80, 13'(i), 1'b1, 1'b0);
    idle(4);
    reset_n = 1'b0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'd90, 13'(20 + i), 1'b1, 1'b0);
    send_fe();
    idle(6);

    // Calibration withdrawn: report the empty frame, then back to IDLE.
    ref_valid = 1'b0;
    send_fe();
    idle(6);
    trk = 1'b0;
    for (int i = 0; i < 3; i++) drive_pix(8'd200, 8'd100, 8'd50, 13'd1, 13'(i), 1'b1, 1'b0);
    idle(6);

    chk("pix_scoreboard_drained", sb.size(), 0);
    chk("box_scoreboard_drained", bsb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hsv_match_tracker.md
# hsv_match_tracker

Streaming colour matcher and per-frame bounding-box tracker. It consumes the calibrated reference colour (H, S=diff, V=max) produced by the calibration block. For each valid pixel it converts RGB to the same unnormalised H/diff/max representation and flags the pixel if it lies within tolerance of the reference. Over each frame it accumulates the match count and bounding box, then reports them at frame end.

## Interface
- H_TOL, default 14'd8: max |H - ref_H| for a match.
- S_TOL, default 8'd16: max |diff - ref_S| for a match.
- V_TOL, default 8'd32: max |max - ref_V| for a match.
- MIN_COUNT, default 20'd16: minimum matched pixels for `box_found`.
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- pix_valid  in  1  pixel qualifier
- raw_R, raw_G, raw_B  in  8 each  pixel colour
- row, col  in  13 each  pixel coordinates
- frame_end  in  1  one-cycle pulse; last pixel of frame is the one presented in this cycle or earlier
- ref_valid  in  1  calibration result stable
- ref_H  in  14 signed  calibrated hue
- ref_S  in  8  calibrated diff
- ref_V  in  8  calibrated max
- match  out  1  current pipelined pixel matches
- match_valid  out  1  qualifier for `match`, `out_R/G/B`
- out_R, out_G, out_B  out  8 each  pixel stream, 3-cycle delayed
- box_valid  out  1  one-cycle report pulse
- box_found  out  1  count >= MIN_COUNT
- box_count  out  20  matched pixels in frame (saturating)
- box_rmin, box_rmax, box_cmin, box_cmax  out  13 each  bounding box

## Operation
- Conversion: max and min of R,G,B; diff = max - min. H (signed 14) = G-B if max==R; else (B-R)+2·diff if max==G; else (R-G)+4·diff. Ties resolve R before G before B. Unsigned 8-bit inputs are zero-extended before subtraction.
- Match: state TRACK, and |H-ref_H| <= H_TOL, |diff-ref_S| <= S_TOL, |max-ref_V| <= V_TOL, all computed at 15-bit signed width.
- FSM states:
  - IDLE: `match`=0 and no accumulation. When ref_valid=1, latch ref_H/S/V into internal registers and go to TRACK.
  - TRACK: accumulate on every matched pixel. `count` increments, saturating at 2^20-1. rmin/rmax/cmin/cmax are updated with min/max against the pixel's row/col. The delayed frame_end moves the FSM to REPORT.
  - REPORT: `box_valid`=1 for exactly one cycle with the frozen results. Accumulators are then cleared to count=0, min=8191, max=0. Next state is TRACK if ref_valid=1, else IDLE.
- Reference values stay latched for the whole frame. They are re-latched only on the IDLE→TRACK transition, so a recalibration takes effect at a frame boundary.
- Empty frame (count=0): box_found=0 and all four box outputs report 0.
- A pixel with pix_valid and frame_end in the same cycle belongs to the ending frame.
- A pixel that arrives in a cycle where the FSM is in REPORT is counted into the next frame.

## Timing
- Latency is 3 cycles from pix_valid to match_valid/match/out_*. The stages are: S1 register RGB, max, min; S2 register H, diff, max; S3 compare.
- frame_end travels through the same 3-stage delay. box_valid asserts 1 cycle after the delayed frame_end, i.e. 4 cycles after the input pulse.
- Full throughput: one pixel per cycle, no backpressure.
- Reset values:
  - All outputs 0; box_rmin and box_cmin are also 0.
  - Internal min trackers reset to 8191.
  - FSM state IDLE; pipeline valid bits cleared.
- Reset mid-frame discards the pipeline and partial accumulators. No box_valid is issued for that frame.

## Configuration
- HSV_MATCH_OVERLAY_EN defined: out_R/G/B carry the 3-cycle-delayed pixel, with matched pixels replaced by pure green (0,255,0). Box-edge pixels (row==last box_rmin/rmax or col==last box_cmin/cmax within the box) are painted red (255,0,0); the last box is the one from the previous report.
- Not defined: out_R/G/B carry the delayed pixel unmodified. No overlay logic is synthesised.

## Structure
- Package hsv_pkg holds:
  - H width constant (14)
  - coordinate width (13)
  - count width (20)
  - FSM state typedef {IDLE, TRACK, REPORT}
  - overlay colour constants
- One sub-module, hsv_convert: the 2-stage RGB→(H, diff, max) pipeline. The calibration block shares the same conversion equations.

## Test plan
- Ref (H=50, S=150, V=200). Pixel (200,100,50) → H=50, diff=150, max=200; match=1 three cycles after pix_valid.
- Same ref. Pixel (50,200,100) → H=350; match=0.
- ref_valid=0, matching pixels, then frame_end → match=0 throughout and no box_valid.
- 20 matching pixels at rows 10..14, cols 30..33, then frame_end → box_valid 4 cycles later; count=20, found=1, rmin=10, rmax=14, cmin=30, cmax=33.
- frame_end with zero matches → box_valid=1, found=0, count=0, box coordinates 0. Last matching pixel coincident with frame_end → counted in the reported frame.
- reset_n low mid-frame after 10 matches → no report. The next frame with 5 matches reports count=5.
